// File: rtl/traffic_density_estimator.sv
// traffic_density_estimator
// Counts vehicle-detector pulses on four approaches (N/E/S/W) over a fixed
// window and quantises each count into a 2-bit density code (00 light .. 11
// heavy). Codes are registered and held for a whole window.
// Optional macro DENSITY_HYST_EN: an output only changes once two consecutive
// windows classify to the same new code.
module traffic_density_estimator #(
  parameter int WINDOW_CYCLES = 100,
  parameter int CNT_W         = 8,
  parameter int TH_LOW        = 2,
  parameter int TH_MED        = 5,
  parameter int TH_HIGH       = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sensor_N,
  input  logic       sensor_E,
  input  logic       sensor_S,
  input  logic       sensor_W,
  output logic [1:0] traffic_density_N,
  output logic [1:0] traffic_density_E,
  output logic [1:0] traffic_density_S,
  output logic [1:0] traffic_density_W,
  output logic       density_valid
);

  localparam int              WIN_W     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TH_LOW_C = CNT_W'(TH_LOW);
  localparam logic [CNT_W-1:0] TH_MED_C = CNT_W'(TH_MED);
  localparam logic [CNT_W-1:0] TH_HIGH_C = CNT_W'(TH_HIGH);

  // Bit order everywhere: 0=N, 1=E, 2=S, 3=W
  logic [3:0]       w_sensor;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_prev;
  logic [3:0]       w_edge;
  logic [WIN_W-1:0] r_win;
  logic             w_close;
  logic             r_valid;
  logic [7:0]       w_dens;

  assign w_sensor = {sensor_W, sensor_S, sensor_E, sensor_N};

  // Two-flop synchroniser plus previous-value register; runs even when en=0
  // so re-enabling never fabricates an edge from a level that is already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_sensor;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge  = r_sync2 & ~r_prev;
  assign w_close = en && (r_win == WIN_LAST);

  // Window position counter, frozen while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (en) begin
      r_win <= (r_win == WIN_LAST) ? '0 : r_win + 1'b1;
    end
  end

  // One-cycle strobe following each close cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_close;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dir
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_inc;
      logic [1:0]       w_code;
      logic [1:0]       r_dens;

      // Count including this cycle's edge, so an edge in the close cycle
      // still lands in the window that is closing.
      assign w_cnt_inc = (w_edge[gi] && (r_cnt != CNT_MAX)) ? r_cnt + CNT_ONE : r_cnt;

      // Threshold classification of the closing count.
      always_comb begin
        w_code = 2'b00;
        if (w_cnt_inc >= TH_HIGH_C)     w_code = 2'b11;
        else if (w_cnt_inc >= TH_MED_C) w_code = 2'b10;
        else if (w_cnt_inc >= TH_LOW_C) w_code = 2'b01;
      end

      // Saturating pulse counter, restarted after each close cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (en) begin
          r_cnt <= w_close ? '0 : w_cnt_inc;
        end
      end

`ifdef DENSITY_HYST_EN
      logic [1:0] r_pend;
      logic       r_agree;

      // Output follows a new code only after it has been seen twice in a row.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dens  <= 2'b00;
          r_pend  <= 2'b00;
          r_agree <= 1'b0;
        end else if (w_close) begin
          if (w_code == r_dens) begin
            r_pend  <= w_code;
            r_agree <= 1'b0;
          end else if (r_agree && (r_pend == w_code)) begin
            r_dens  <= w_code;
            r_agree <= 1'b0;
          end else begin
            r_pend  <= w_code;
            r_agree <= 1'b1;
          end
        end
      end
`else
      // Output takes the fresh classification at every window close.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dens <= 2'b00;
        end else if (w_close) begin
          r_dens <= w_code;
        end
      end
`endif

      assign w_dens[2*gi +: 2] = r_dens;
    end
  endgenerate

  assign traffic_density_N = w_dens[1:0];
  assign traffic_density_E = w_dens[3:2];
  assign traffic_density_S = w_dens[5:4];
  assign traffic_density_W = w_dens[7:6];
  assign density_valid     = r_valid;

endmodule

// File: tb/tb_traffic_density_estimator.sv
// Self-checking bench for traffic_density_estimator. Two instances share the
// stimulus: a default-width one and a 3-bit counter one (saturation case).
module tb_traffic_density_estimator;

  localparam int W = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] sens = 4'b0;   // 0=N 1=E 2=S 3=W
  logic [7:0] dens0, dens1;  // {W,S,E,N}
  logic       v0, v1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_density_estimator #(.WINDOW_CYCLES(W), .CNT_W(8), .TH_LOW(2), .TH_MED(5), .TH_HIGH(9)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .sensor_N(sens[0]), .sensor_E(sens[1]), .sensor_S(sens[2]), .sensor_W(sens[3]),
    .traffic_density_N(dens0[1:0]), .traffic_density_E(dens0[3:2]),
    .traffic_density_S(dens0[5:4]), .traffic_density_W(dens0[7:6]),
    .density_valid(v0));

  traffic_density_estimator #(.WINDOW_CYCLES(W), .CNT_W(3), .TH_LOW(2), .TH_MED(4), .TH_HIGH(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .sensor_N(sens[0]), .sensor_E(sens[1]), .sensor_S(sens[2]), .sensor_W(sens[3]),
    .traffic_density_N(dens1[1:0]), .traffic_density_E(dens1[3:2]),
    .traffic_density_S(dens1[5:4]), .traffic_density_W(dens1[7:6]),
    .density_valid(v1));

  // ---------------- reference model ----------------
  // A raw rise sampled at edge t-2 (after being low at t-3) is counted at
  // edge t if en is high there; the W-th enabled edge closes the window.
  logic [3:0] ring [8];
  int         cyc;
  int         menc;
  int         mcnt  [2][4];
  logic [1:0] mdens [2][4];
  logic [1:0] mlast [2][4];
  logic       mvalid;

  function automatic logic [1:0] cls(input int c, input int k);
    int l, m, h;
    if (k == 0) begin l = 2; m = 5; h = 9; end
    else        begin l = 2; m = 4; h = 6; end
    if (c >= h) return 2'b11;
    if (c >= m) return 2'b10;
    if (c >= l) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat_add(input int c, input int p, input int k);
    int mx;
    mx = (k == 0) ? 255 : 7;
    return (c + p > mx) ? mx : c + p;
  endfunction

  function automatic int pulse(input int d);
    return (ring[(cyc + 6) % 8][d] && !ring[(cyc + 5) % 8][d]) ? 1 : 0;
  endfunction

  function automatic logic [1:0] newc(input int k, input int d);
    return cls(sat_add(mcnt[k][d], pulse(d), k), k);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) ring[i] <= 4'b0;
      cyc    <= 0;
      menc   <= 0;
      mvalid <= 1'b0;
      for (int k = 0; k < 2; k++)
        for (int d = 0; d < 4; d++) begin
          mcnt[k][d]  <= 0;
          mdens[k][d] <= 2'b00;
          mlast[k][d] <= 2'b00;
        end
    end else begin
      ring[cyc % 8] <= sens;
      cyc    <= cyc + 1;
      mvalid <= 1'b0;
      if (en) begin
        if (menc == W - 1) begin
          menc   <= 0;
          mvalid <= 1'b1;
          for (int k = 0; k < 2; k++)
            for (int d = 0; d < 4; d++) begin
              mcnt[k][d] <= 0;
`ifdef DENSITY_HYST_EN
              if (newc(k, d) == mlast[k][d] && newc(k, d) != mdens[k][d])
                mdens[k][d] <= newc(k, d);
              mlast[k][d] <= newc(k, d);
`else
              mdens[k][d] <= newc(k, d);
`endif
            end
        end else begin
          menc <= menc + 1;
          for (int k = 0; k < 2; k++)
            for (int d = 0; d < 4; d++)
              mcnt[k][d] <= sat_add(mcnt[k][d], pulse(d), k);
        end
      end
    end
  end

  logic [17:0] exp_vec, obs_vec;
  assign exp_vec = {mdens[0][3], mdens[0][2], mdens[0][1], mdens[0][0],
                    mdens[1][3], mdens[1][2], mdens[1][1], mdens[1][0], mvalid, mvalid};
  assign obs_vec = {dens0, dens1, v0, v1};

  // pulse train: n pulses, 2 cycles high / 3 low, starting at index start
  function automatic logic pat(input int i, input int n, input int start);
    return (n > 0) && (i >= start) && (i < start + 5 * n) && (((i - start) % 5) < 2);
  endfunction

  // Waits (bounded) for the model's window-close strobe at a negedge.
  task automatic wait_window();
    int n = 0;
    @(negedge clk);
    while (!mvalid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!mvalid) begin
      checks++;
      failures++;
      $display("FAIL wait_window timeout: valid=%b required=1", mvalid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int nval = 0;
    rst_n = 1'b0; en = 1'b0; sens = 4'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_vec !== 18'b0) begin
      failures++;
      $display("FAIL reset_state got=%h required=00000", obs_vec);
    end
    en = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i <= 3 * W + 5; i++) begin
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL idle_model i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
      if (i == W || i == 2 * W || i == 3 * W) begin
        checks++;
        if (v0 !== 1'b1 || dens0 !== 8'h00) begin
          failures++;
          $display("FAIL idle_close i=%0d valid=%b dens=%h required valid=1 dens=00", i, v0, dens0);
        end
      end
      if (v0 === 1'b1) nval++;
      if (i < 3 * W + 5) @(negedge clk);
    end
    checks++;
    if (nval != 3) begin
      failures++;
      $display("FAIL idle_valid_count got=%0d required=3", nval);
    end
  endtask

  task automatic test_densities();
    wait_window();
    for (int i = 0; i <= W; i++) begin
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL dens_model i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
      if (i == W) begin
        checks++;
        if (dens0 !== 8'b00_11_10_01 || v0 !== 1'b1) begin
          failures++;
          $display("FAIL dens_codes dut0 got=%b valid=%b required=00111001 valid=1", dens0, v0);
        end
        checks++;
        if (dens1 !== 8'b00_11_11_01) begin
          failures++;
          $display("FAIL dens_codes dut1 got=%b required=00111101", dens1);
        end
      end
      sens = {1'b0, pat(i, 10, 2), pat(i, 6, 2), pat(i, 3, 2)};
      if (i < W) @(negedge clk);
    end
    sens = 4'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 30; i++) begin
      sens = {3'b0, pat(i, 4, 2)};
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dens0 !== 8'h00 || dens1 !== 8'h00 || v0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear dens0=%h dens1=%h valid=%b required 00 00 0", dens0, dens1, v0);
    end
    sens = 4'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= W; i++) begin
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL reset_mid_model i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
      checks++;
      if (v0 !== (i == W)) begin
        failures++;
        $display("FAIL reset_mid_valid i=%0d got=%b required=%b", i, v0, (i == W));
      end
      if (i < W) @(negedge clk);
    end
  endtask

  task automatic test_held();
    wait_window();
    for (int i = 0; i <= W; i++) begin
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL held_model i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
      if (i == W) begin
        checks++;
        if (dens0[3:2] !== 2'b00 || dens1[3:2] !== 2'b00) begin
          failures++;
          $display("FAIL held_once E0=%b E1=%b required 00", dens0[3:2], dens1[3:2]);
        end
      end
      sens = {2'b0, (i >= 2 && i < 52), 1'b0};
      if (i < W) @(negedge clk);
    end
    sens = 4'b0;
  endtask

  task automatic test_boundary();
    wait_window();
    for (int i = 0; i <= 2 * W; i++) begin
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL boundary_model i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
      if (i == W) begin
        checks++;
        if (dens0[1:0] !== 2'b01 || dens0[3:2] !== 2'b00) begin
          failures++;
          $display("FAIL boundary_close N=%b E=%b required N=01 E=00", dens0[1:0], dens0[3:2]);
        end
      end
      if (i == 2 * W) begin
        checks++;
        if (dens0[1:0] !== 2'b00 || dens0[3:2] !== 2'b01) begin
          failures++;
          $display("FAIL boundary_next N=%b E=%b required N=00 E=01", dens0[1:0], dens0[3:2]);
        end
      end
      sens = {2'b0,
              pat(i, 1, 5) || i == 78 || i == 79 || pat(i, 1, 85),
              pat(i, 1, 5) || i == 77 || i == 78};
      if (i < 2 * W) @(negedge clk);
    end
    sens = 4'b0;
  endtask

  task automatic test_saturation();
    wait_window();
    for (int i = 0; i <= 2 * W; i++) begin
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL sat_model i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
      if (i == W) begin
        checks++;
        if (dens0[1:0] !== 2'b11 || dens1[1:0] !== 2'b11) begin
          failures++;
          $display("FAIL sat_heavy N0=%b N1=%b required 11", dens0[1:0], dens1[1:0]);
        end
      end
      if (i == 2 * W) begin
        checks++;
        if (dens0[1:0] !== 2'b00 || dens1[1:0] !== 2'b00) begin
          failures++;
          $display("FAIL sat_empty N0=%b N1=%b required 00", dens0[1:0], dens1[1:0]);
        end
      end
      sens = {3'b0, (i < W) && pat(i, 12, 2)};
      if (i < 2 * W) @(negedge clk);
    end
    sens = 4'b0;
  endtask

  task automatic test_en_low();
    wait_window();
    for (int i = 0; i <= W + 15; i++) begin
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL enlow_model i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
      if (i == W) begin
        checks++;
        if (v0 !== 1'b0) begin
          failures++;
          $display("FAIL enlow_not_yet valid=%b required=0", v0);
        end
      end
      if (i == W + 15) begin
        checks++;
        if (v0 !== 1'b1 || dens0[1:0] !== 2'b00 || dens0[7:6] !== 2'b00) begin
          failures++;
          $display("FAIL enlow_late_close valid=%b N=%b W=%b required 1 00 00", v0, dens0[1:0], dens0[7:6]);
        end
      end
      en   = !(i >= 20 && i < 35);
      sens = {pat(i, 1, 5) || (i >= 30 && i < 50), 2'b0,
              (i == 21 || i == 22 || i == 26 || i == 27 || i == 31 || i == 32)};
      if (i < W + 15) @(negedge clk);
    end
    en = 1'b1;
    sens = 4'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 5 * W; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL random_model i=%0d got=%h required=%h", i, obs_vec, exp_vec);
      end
      if ($urandom_range(0, 2) == 0) sens = 4'($urandom);
      en = ($urandom_range(0, 9) != 0);
    end
    en = 1'b1;
    sens = 4'b0;
  endtask

  initial begin
    test_reset();
    test_densities();
    test_reset_mid();
    test_held();
    test_boundary();
    test_saturation();
    test_en_low();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
